// File: rtl/program_loader_pkg.sv
// Shared types and constants for the CPU program loader.
package program_loader_pkg;

  localparam int ADDR_W  = 8;
  localparam int DATA_W  = 8;
  localparam int COUNT_W = 9;
  localparam int PCNT_W  = 4;

  localparam logic [COUNT_W-1:0] COUNT_MAX = 9'd256;

  typedef enum logic [3:0] {
    ST_IDLE       = 4'd0,
    ST_NEXT       = 4'd1,
    ST_ADDR_PULSE = 4'd2,
    ST_ADDR_REL   = 4'd3,
    ST_DATA_PULSE = 4'd4,
    ST_DATA_REL   = 4'd5,
    ST_EXEC_PULSE = 4'd6,
    ST_EXEC_REL   = 4'd7,
    ST_RUN        = 4'd8,
    ST_IN_PULSE   = 4'd9,
    ST_IN_REL     = 4'd10
  } state_e;

  // True for the four states that hold a button-style pulse high.
  function automatic logic is_pulse_state(input state_e s);
    logic r;
    r = 1'b0;
    case (s)
      ST_ADDR_PULSE, ST_DATA_PULSE, ST_EXEC_PULSE, ST_IN_PULSE: r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/program_loader_pulse_timer.sv
// Down-counter that times how long a pulse state is held.
// Loaded on entry to a pulse state; o_done is high in the last pulse cycle.
module pulse_timer
  import program_loader_pkg::*;
#(
  parameter int PULSE_CYCLES = 2
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_load,
  output logic o_done
);

  logic [PCNT_W-1:0] cnt_q;
  logic [PCNT_W-1:0] cnt_d;

  // Next count: reload on state entry, otherwise count down to zero and stop.
  always_comb begin
    cnt_d = cnt_q;
    if (i_load) begin
      cnt_d = PCNT_W'(PULSE_CYCLES - 1);
    end else if (cnt_q != 4'd0) begin
      cnt_d = cnt_q - 4'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_done = (cnt_q == 4'd0);

endmodule

// File: rtl/program_loader.sv
// Host-side driver for the CPU manual load/execute interface: writes a
// program byte stream into CPU RAM, pulses execute, then feeds WRIM input
// requests from a second stream until the CPU halts.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int PULSE_CYCLES = 2
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic [ADDR_W-1:0]  i_base,
  input  logic               i_prog_valid,
  input  logic [DATA_W-1:0]  i_prog_data,
  input  logic               i_prog_last,
  output logic               o_prog_ready,
  input  logic               i_in_valid,
  input  logic [DATA_W-1:0]  i_in_data,
  output logic               o_in_ready,
  output logic               o_cpu_load_addr,
  output logic               o_cpu_load_data,
  output logic               o_cpu_execute,
  output logic               o_cpu_input_taken,
  output logic [DATA_W-1:0]  o_cpu_data,
  input  logic               i_cpu_waiting,
  input  logic               i_cpu_take_input,
  output logic               o_busy,
  output logic               o_running,
  output logic               o_done,
  output logic [COUNT_W-1:0] o_count,
  output logic               o_wrap
);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   hold_q, hold_d;
  logic                last_q, last_d;
  logic [DATA_W-1:0]   in_byte_q, in_byte_d;
  logic [COUNT_W-1:0]  count_q, count_d;
  logic                wrap_q, wrap_d;
  logic                done_q, done_d;
  logic                load_addr_q, load_addr_d;
  logic                load_data_q, load_data_d;
  logic                execute_q, execute_d;
  logic                input_taken_q, input_taken_d;
  logic [DATA_W-1:0]   cpu_data_q, cpu_data_d;
  logic                busy_q, busy_d;
  logic                running_q, running_d;

  logic st_loadidle, st_loaddata, st_wrimreq;
  logic timer_load, timer_done;

  // CPU status decode: which side of the manual interface the CPU is on.
  assign st_loadidle = i_cpu_waiting  & ~i_cpu_take_input;
  assign st_loaddata = ~i_cpu_waiting &  i_cpu_take_input;
  assign st_wrimreq  = i_cpu_waiting  &  i_cpu_take_input;

  // Ready depends only on state and CPU status, never on the valid inputs.
  assign o_prog_ready = (state_q == ST_NEXT) & st_loadidle;
  assign o_in_ready   = (state_q == ST_RUN)  & st_wrimreq;

  assign timer_load = (state_d != state_q) & is_pulse_state(state_d);

  pulse_timer #(.PULSE_CYCLES(PULSE_CYCLES)) u_timer (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_load  (timer_load),
    .o_done  (timer_done)
  );

  // Sequencer: next state plus address, holding register and load statistics.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    hold_d    = hold_q;
    last_d    = last_q;
    in_byte_d = in_byte_q;
    count_d   = count_q;
    wrap_d    = wrap_q;
    done_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          addr_d  = i_base;
          count_d = 9'd0;
          wrap_d  = 1'b0;
          state_d = ST_NEXT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_NEXT: begin
        if (i_prog_valid && o_prog_ready) begin
          hold_d  = i_prog_data;
          last_d  = i_prog_last;
          state_d = ST_ADDR_PULSE;
        end else begin
          state_d = ST_NEXT;
        end
      end
      ST_ADDR_PULSE: begin
        state_d = timer_done ? ST_ADDR_REL : ST_ADDR_PULSE;
      end
      ST_ADDR_REL: begin
        state_d = st_loaddata ? ST_DATA_PULSE : ST_ADDR_REL;
      end
      ST_DATA_PULSE: begin
        state_d = timer_done ? ST_DATA_REL : ST_DATA_PULSE;
      end
      ST_DATA_REL: begin
        if (st_loadidle) begin
          count_d = (count_q == COUNT_MAX) ? count_q : (count_q + 9'd1);
          addr_d  = addr_q + 8'd1;
          if (addr_q == 8'hFF) begin
            wrap_d = 1'b1;
          end else begin
            wrap_d = wrap_q;
          end
          state_d = last_q ? ST_EXEC_PULSE : ST_NEXT;
        end else begin
          state_d = ST_DATA_REL;
        end
      end
      ST_EXEC_PULSE: begin
        state_d = timer_done ? ST_EXEC_REL : ST_EXEC_PULSE;
      end
      ST_EXEC_REL: begin
        // The CPU is still in its load-address state until execute is seen.
        state_d = i_cpu_waiting ? ST_EXEC_REL : ST_RUN;
      end
      ST_RUN: begin
        if (st_loadidle) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else if (i_in_valid && o_in_ready) begin
          in_byte_d = i_in_data;
          state_d   = ST_IN_PULSE;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_IN_PULSE: begin
        state_d = timer_done ? ST_IN_REL : ST_IN_PULSE;
      end
      ST_IN_REL: begin
        state_d = st_wrimreq ? ST_IN_REL : ST_RUN;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output decode from the next state so every output is a plain flop.
  always_comb begin
    load_addr_d   = (state_d == ST_ADDR_PULSE);
    load_data_d   = (state_d == ST_DATA_PULSE);
    execute_d     = (state_d == ST_EXEC_PULSE);
    input_taken_d = (state_d == ST_IN_PULSE);
    busy_d        = (state_d != ST_IDLE);
    running_d     = (state_d == ST_RUN) | (state_d == ST_IN_PULSE) | (state_d == ST_IN_REL);
    cpu_data_d    = 8'h00;
    case (state_d)
      ST_ADDR_PULSE: cpu_data_d = addr_d;
      ST_ADDR_REL, ST_DATA_PULSE, ST_DATA_REL: cpu_data_d = hold_d;
      ST_IN_PULSE, ST_IN_REL: cpu_data_d = in_byte_d;
      default: cpu_data_d = 8'h00;
    endcase
  end

  // State and registered outputs, cleared by synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q       <= ST_IDLE;
      addr_q        <= 8'h00;
      hold_q        <= 8'h00;
      last_q        <= 1'b0;
      in_byte_q     <= 8'h00;
      count_q       <= 9'd0;
      wrap_q        <= 1'b0;
      done_q        <= 1'b0;
      load_addr_q   <= 1'b0;
      load_data_q   <= 1'b0;
      execute_q     <= 1'b0;
      input_taken_q <= 1'b0;
      cpu_data_q    <= 8'h00;
      busy_q        <= 1'b0;
      running_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      hold_q        <= hold_d;
      last_q        <= last_d;
      in_byte_q     <= in_byte_d;
      count_q       <= count_d;
      wrap_q        <= wrap_d;
      done_q        <= done_d;
      load_addr_q   <= load_addr_d;
      load_data_q   <= load_data_d;
      execute_q     <= execute_d;
      input_taken_q <= input_taken_d;
      cpu_data_q    <= cpu_data_d;
      busy_q        <= busy_d;
      running_q     <= running_d;
    end
  end

  assign o_cpu_load_addr   = load_addr_q;
  assign o_cpu_load_data   = load_data_q;
  assign o_cpu_execute     = execute_q;
  assign o_cpu_input_taken = input_taken_q;
  assign o_cpu_data        = cpu_data_q;
  assign o_busy            = busy_q;
  assign o_running         = running_q;
  assign o_done            = done_q;
  assign o_count           = count_q;
  assign o_wrap            = wrap_q;

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: three instances (PULSE_CYCLES 2, 1, 4), each
// attached to a small behavioural CPU model with RAM, NOOP/WRIM/HALT.
module tb_program_loader;

  localparam int NI = 3;

  typedef struct packed {
    logic [7:0]      base;
    logic [3:0]      n;
    logic [3:0][7:0] prog;
    logic [7:0]      in_byte;
    logic [7:0]      in_delay;
    logic            rnd;
    logic            glitch;
    logic [8:0]      exp_count;
    logic            exp_wrap;
    logic [7:0]      chk_addr;
    logic [7:0]      chk_data;
    logic [1:0]      exp_in_hs;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [NI-1:0] start, prog_valid, prog_last, in_valid;
  logic [7:0]    base [NI];
  logic [7:0]    prog_data [NI];
  logic [7:0]    in_data [NI];
  logic [NI-1:0] prog_ready, in_ready, c_la, c_ld, c_ex, c_it, c_wait, c_take;
  logic [NI-1:0] busy, running, done_o, wrap;
  logic [7:0]    c_data [NI];
  logic [8:0]    count [NI];

  logic [NI-1:0]   order_ok, width_ok;
  logic [15:0]     wcnt [NI];
  logic [7:0]      rd_data [NI];
  logic [7:0]      rd_addr;
  logic            clr_flags;
  logic [7:0]      cur_base;
  logic [3:0][7:0] cur_prog;
  logic [3:0]      cur_n;

  int checks = 0;
  int failures = 0;

  for (genvar g = 0; g < NI; g++) begin : inst
    localparam int P = (g == 0) ? 2 : ((g == 1) ? 1 : 4);
    localparam logic [1:0] M_LA = 2'd0, M_LD = 2'd1, M_RUN = 2'd2, M_WRIM = 2'd3;

    program_loader #(.PULSE_CYCLES(P)) dut (
      .i_clk(clk), .i_reset(rst), .i_start(start[g]), .i_base(base[g]),
      .i_prog_valid(prog_valid[g]), .i_prog_data(prog_data[g]),
      .i_prog_last(prog_last[g]), .o_prog_ready(prog_ready[g]),
      .i_in_valid(in_valid[g]), .i_in_data(in_data[g]), .o_in_ready(in_ready[g]),
      .o_cpu_load_addr(c_la[g]), .o_cpu_load_data(c_ld[g]),
      .o_cpu_execute(c_ex[g]), .o_cpu_input_taken(c_it[g]),
      .o_cpu_data(c_data[g]), .i_cpu_waiting(c_wait[g]),
      .i_cpu_take_input(c_take[g]), .o_busy(busy[g]), .o_running(running[g]),
      .o_done(done_o[g]), .o_count(count[g]), .o_wrap(wrap[g])
    );

    logic [1:0]  ms;
    logic [7:0]  ram [256];
    logic [7:0]  lat, a_lat, pc, start_pc, wr_addr;
    logic        fresh, p_la, p_ld, p_ex, p_it, ook, wok;
    int          w_la, w_ld;
    logic [15:0] wc;

    assign c_wait[g]   = (ms == M_LA) || (ms == M_WRIM);
    assign c_take[g]   = (ms == M_LD) || (ms == M_WRIM);
    assign rd_data[g]  = ram[rd_addr];
    assign order_ok[g] = ook;
    assign width_ok[g] = wok;
    assign wcnt[g]     = wc;

    // CPU model: acts on release of each button pulse, one instruction per cycle.
    always @(posedge clk) begin
      if (rst) begin
        ms <= M_LA; fresh <= 1'b1; p_la <= 1'b0; p_ld <= 1'b0; p_ex <= 1'b0; p_it <= 1'b0;
        w_la <= 0; w_ld <= 0; pc <= 8'h00; start_pc <= 8'h00; lat <= 8'h00;
        a_lat <= 8'h00; wr_addr <= 8'h00; ook <= 1'b1; wok <= 1'b1; wc <= 16'd0;
        for (int i = 0; i < 256; i++) ram[i] <= 8'h00;
      end else begin
        if (clr_flags) begin
          ook <= 1'b1; wok <= 1'b1; wc <= 16'd0;
        end
        p_la <= c_la[g]; p_ld <= c_ld[g]; p_ex <= c_ex[g]; p_it <= c_it[g];
        if (c_la[g] || c_ld[g] || c_it[g]) lat <= c_data[g];
        w_la <= c_la[g] ? w_la + 1 : 0;
        w_ld <= c_ld[g] ? w_ld + 1 : 0;
        if (p_la && !c_la[g] && w_la != P) wok <= 1'b0;
        if (p_ld && !c_ld[g] && w_ld != P) wok <= 1'b0;
        case (ms)
          M_LA: begin
            if (p_la && !c_la[g]) begin
              a_lat <= lat; ms <= M_LD;
              if (fresh) begin start_pc <= lat; fresh <= 1'b0; end
            end else if (p_ex && !c_ex[g]) begin
              pc <= start_pc; ms <= M_RUN;
            end
          end
          M_LD: begin
            if (p_ld && !c_ld[g]) begin
              ram[a_lat] <= lat; ms <= M_LA; wc <= wc + 16'd1;
              if (wc >= 16'(cur_n) || lat != cur_prog[wc[1:0]] || a_lat != cur_base + wc[7:0])
                ook <= 1'b0;
            end
          end
          M_RUN: begin
            case (ram[pc])
              8'h00: begin ms <= M_LA; fresh <= 1'b1; end
              8'h02: begin wr_addr <= ram[pc + 8'd1]; pc <= pc + 8'd2; ms <= M_WRIM; end
              default: pc <= pc + 8'd1;
            endcase
          end
          default: begin
            if (p_it && !c_it[g]) begin ram[wr_addr] <= lat; ms <= M_RUN; end
          end
        endcase
      end
    end
  end

  task automatic chk(input string nm, input int g, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[inst%0d]: got %0h expected %0h", nm, g, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int vi);
    int  pidx [NI];
    int  dly [NI];
    int  inhs [NI];
    int  dones [NI];
    bit  given [NI];
    bit  tp [NI];
    bit  ti [NI];
    bit  all_done, glitched, gl_pend;
    all_done = 1'b0; glitched = 1'b0; gl_pend = 1'b0;
    cur_base = v.base; cur_prog = v.prog; cur_n = v.n;
    clr_flags = 1'b1;
    @(posedge clk); #1;
    clr_flags = 1'b0;
    for (int g = 0; g < NI; g++) begin
      pidx[g] = 0; dly[g] = 0; inhs[g] = 0; dones[g] = 0; given[g] = 1'b0;
      base[g] = v.base; start[g] = 1'b1;
    end
    @(posedge clk); #1;
    start = '0;
    for (int cyc = 0; cyc < 3000 && !all_done; cyc++) begin
      for (int g = 0; g < NI; g++) begin
        if (pidx[g] < int'(v.n)) begin
          prog_valid[g] = v.rnd ? ($urandom_range(1, 0) != 0) : 1'b1;
          prog_data[g]  = v.prog[pidx[g]];
          prog_last[g]  = (pidx[g] == int'(v.n) - 1);
        end else begin
          prog_valid[g] = 1'b0;
        end
        if (!given[g] && running[g] && c_wait[g] && c_take[g]) begin
          if (dly[g] >= int'(v.in_delay)) begin
            in_valid[g] = 1'b1; in_data[g] = v.in_byte;
          end else begin
            dly[g]++;
          end
        end
      end
      if (v.glitch && !glitched && !given[0] && dly[0] == int'(v.in_delay) / 2 && dly[0] > 0) begin
        start[0] = 1'b1; base[0] = 8'h77; glitched = 1'b1; gl_pend = 1'b1;
      end
      @(negedge clk);
      for (int g = 0; g < NI; g++) begin
        tp[g] = prog_valid[g] && prog_ready[g];
        ti[g] = in_valid[g] && in_ready[g];
        if (done_o[g]) dones[g]++;
      end
      @(posedge clk); #1;
      if (gl_pend) begin
        start[0] = 1'b0; gl_pend = 1'b0;
        chk($sformatf("v%0d_glitch_running", vi), 0, 32'(running[0]), 32'd1);
        chk($sformatf("v%0d_glitch_count", vi), 0, 32'(count[0]), 32'(v.exp_count));
      end
      all_done = 1'b1;
      for (int g = 0; g < NI; g++) begin
        if (tp[g]) pidx[g]++;
        if (ti[g]) begin inhs[g]++; given[g] = 1'b1; in_valid[g] = 1'b0; end
        if (dones[g] == 0) all_done = 1'b0;
      end
    end
    prog_valid = '0; in_valid = '0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      for (int g = 0; g < NI; g++) if (done_o[g]) dones[g]++;
    end
    rd_addr = v.chk_addr;
    #1;
    if (!all_done) chk($sformatf("v%0d_timeout", vi), 0, 32'd0, 32'd1);
    if (v.glitch) chk($sformatf("v%0d_glitch_seen", vi), 0, 32'(glitched), 32'd1);
    for (int g = 0; g < NI; g++) begin
      chk($sformatf("v%0d_count", vi), g, 32'(count[g]), 32'(v.exp_count));
      chk($sformatf("v%0d_wrap", vi), g, 32'(wrap[g]), 32'(v.exp_wrap));
      chk($sformatf("v%0d_order", vi), g, 32'(order_ok[g]), 32'd1);
      chk($sformatf("v%0d_pulse_width", vi), g, 32'(width_ok[g]), 32'd1);
      chk($sformatf("v%0d_writes", vi), g, 32'(wcnt[g]), 32'(v.n));
      chk($sformatf("v%0d_ram", vi), g, 32'(rd_data[g]), 32'(v.chk_data));
      chk($sformatf("v%0d_in_hs", vi), g, 32'(inhs[g]), 32'(v.exp_in_hs));
      chk($sformatf("v%0d_done_pulses", vi), g, 32'(dones[g]), 32'd1);
      chk($sformatf("v%0d_busy_after", vi), g, 32'(busy[g]), 32'd0);
    end
  endtask

  vec_t vecs [5];

  initial begin
    vecs[0] = '{base: 8'h10, n: 4'd2, prog: {8'h00, 8'h00, 8'h00, 8'h01}, in_byte: 8'h00,
                in_delay: 8'd0, rnd: 1'b0, glitch: 1'b0, exp_count: 9'd2, exp_wrap: 1'b0,
                chk_addr: 8'h10, chk_data: 8'h01, exp_in_hs: 2'd0};
    vecs[1] = '{base: 8'h00, n: 4'd3, prog: {8'h00, 8'h00, 8'h40, 8'h02}, in_byte: 8'hA5,
                in_delay: 8'd20, rnd: 1'b0, glitch: 1'b0, exp_count: 9'd3, exp_wrap: 1'b0,
                chk_addr: 8'h40, chk_data: 8'hA5, exp_in_hs: 2'd1};
    vecs[2] = '{base: 8'hFF, n: 4'd3, prog: {8'h00, 8'h00, 8'h01, 8'h01}, in_byte: 8'h00,
                in_delay: 8'd0, rnd: 1'b0, glitch: 1'b0, exp_count: 9'd3, exp_wrap: 1'b1,
                chk_addr: 8'h00, chk_data: 8'h01, exp_in_hs: 2'd0};
    vecs[3] = '{base: 8'h30, n: 4'd4, prog: {8'h00, 8'h01, 8'h01, 8'h01}, in_byte: 8'h00,
                in_delay: 8'd0, rnd: 1'b1, glitch: 1'b0, exp_count: 9'd4, exp_wrap: 1'b0,
                chk_addr: 8'h31, chk_data: 8'h01, exp_in_hs: 2'd0};
    vecs[4] = '{base: 8'h50, n: 4'd3, prog: {8'h00, 8'h00, 8'h60, 8'h02}, in_byte: 8'h3C,
                in_delay: 8'd12, rnd: 1'b0, glitch: 1'b1, exp_count: 9'd3, exp_wrap: 1'b0,
                chk_addr: 8'h60, chk_data: 8'h3C, exp_in_hs: 2'd1};

    rst = 1'b1; start = '0; prog_valid = '0; prog_last = '0; in_valid = '0;
    clr_flags = 1'b0; rd_addr = 8'h00; cur_base = 8'h00; cur_prog = '0; cur_n = 4'd0;
    for (int g = 0; g < NI; g++) begin base[g] = 8'h00; prog_data[g] = 8'h00; in_data[g] = 8'h00; end
    repeat (3) @(posedge clk);
    #1;
    for (int g = 0; g < NI; g++) begin
      chk("reset_busy", g, 32'(busy[g]), 32'd0);
      chk("reset_count", g, 32'(count[g]), 32'd0);
      chk("reset_cpu_strobes", g, 32'({c_la[g], c_ld[g], c_ex[g], c_it[g]}), 32'd0);
      chk("reset_cpu_data", g, 32'(c_data[g]), 32'd0);
      chk("reset_done_wrap_run", g, 32'({done_o[g], wrap[g], running[g]}), 32'd0);
      chk("reset_ready", g, 32'({prog_ready[g], in_ready[g]}), 32'd0);
    end
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 5; i++) run_vec(vecs[i], i);

    // Reset while instance 0 holds its data pulse, then reload cleanly.
    begin
      bit seen_ld;
      seen_ld = 1'b0;
      for (int g = 0; g < NI; g++) begin
        base[g] = 8'h20; start[g] = 1'b1;
        prog_valid[g] = 1'b1; prog_data[g] = 8'h01; prog_last[g] = 1'b0;
      end
      @(posedge clk); #1;
      start = '0;
      for (int i = 0; i < 200 && !seen_ld; i++) begin
        @(posedge clk); #1;
        seen_ld = c_ld[0];
      end
      chk("rst_mid_reached_data_pulse", 0, 32'(seen_ld), 32'd1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; prog_valid = '0;
      chk("rst_mid_cpu_strobes", 0, 32'({c_la[0], c_ld[0], c_ex[0], c_it[0]}), 32'd0);
      chk("rst_mid_cpu_data", 0, 32'(c_data[0]), 32'd0);
      chk("rst_mid_busy", 0, 32'(busy[0]), 32'd0);
      chk("rst_mid_count", 0, 32'(count[0]), 32'd0);
      @(posedge clk); #1;
      run_vec(vecs[0], 5);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
